// File: rtl/ac_stream_matcher.sv
// ac_stream_matcher
//   Aho-Corasick match engine. Goto, failure and output tables live in
//   internal synchronous RAMs loaded through a single config write port.
//   Characters arrive on a valid/ready handshake; each one walks goto and
//   failure links and may produce a one-cycle match pulse carrying the
//   pattern ID and the 0-based stream position of the completing char.
//
// Ports
//   CLK, RST         clock, synchronous active-low reset
//   EN               engine enable (low freezes FSM, counters, read data)
//   CFG_WE/SEL/ADDR/WDATA  table write port (0 goto, 1 failure, 2 output),
//                    honoured only while IDLE
//   CHARA_VALID/CHARA/CHARA_READY  character stream handshake
//   MATCH_VALID/PID/POS  match pulse, pattern ID, char position
//   NOW_STATE        current automaton state
//   BUSY             FSM not IDLE
//   ERR              sticky failure-hop-limit flag
//
// Optional feature: define MATCH_COUNT_EN to add MATCH_CNT, a saturating
// count of match pulses.
module ac_stream_matcher #(
  parameter int unsigned STATE_W = 8,
  parameter int unsigned CHAR_W  = 4,
  parameter int unsigned PID_W   = 4,
  parameter int unsigned POS_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      CFG_WE,
  input  logic [1:0]                CFG_SEL,
  input  logic [STATE_W+CHAR_W-1:0] CFG_ADDR,
  input  logic [STATE_W:0]          CFG_WDATA,
  input  logic                      CHARA_VALID,
  input  logic [CHAR_W-1:0]         CHARA,
  output logic                      CHARA_READY,
  output logic                      MATCH_VALID,
  output logic [PID_W-1:0]          MATCH_PID,
  output logic [POS_W-1:0]          MATCH_POS,
  output logic [STATE_W-1:0]        NOW_STATE,
  output logic                      BUSY,
  output logic                      ERR
`ifdef MATCH_COUNT_EN
  ,
  output logic [POS_W-1:0]          MATCH_CNT
`endif
);

  localparam int unsigned GA_W = STATE_W + CHAR_W;
  localparam logic [STATE_W-1:0] HOP_MAX = '1;

  typedef enum logic [1:0] {IDLE, G_WAIT, F_WAIT, O_WAIT} fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] now_q, now_d;
  logic [CHAR_W-1:0]  char_q, char_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   cpos_q, cpos_d;
  logic [STATE_W-1:0] hop_q, hop_d;
  logic               err_q, err_d;
  logic               mv_q, mv_d;
  logic [PID_W-1:0]   mpid_q, mpid_d;
  logic [POS_W-1:0]   mpos_q, mpos_d;

  logic [STATE_W:0]   goto_mem [1 << GA_W];
  logic [STATE_W:0]   fail_mem [1 << STATE_W];
  logic [PID_W:0]     out_mem  [1 << STATE_W];
  logic [STATE_W:0]   goto_rdata_q, fail_rdata_q;
  logic [PID_W:0]     out_rdata_q;

  logic               goto_re, fail_re, out_re;
  logic [GA_W-1:0]    goto_raddr;
  logic [STATE_W-1:0] tab_raddr;
  logic [STATE_W-1:0] fail_next;
  logic               cfg_wr;
  logic               accept;

  assign cfg_wr      = CFG_WE && (fsm_q == IDLE);
  assign CHARA_READY = (fsm_q == IDLE) && EN && !CFG_WE;
  assign accept      = CHARA_READY && CHARA_VALID;

  assign MATCH_VALID = mv_q;
  assign MATCH_PID   = mpid_q;
  assign MATCH_POS   = mpos_q;
  assign NOW_STATE   = now_q;
  assign BUSY        = (fsm_q != IDLE);
  assign ERR         = err_q;

  always_comb begin
    fsm_d      = fsm_q;
    now_d      = now_q;
    char_d     = char_q;
    pos_d      = pos_q;
    cpos_d     = cpos_q;
    hop_d      = hop_q;
    err_d      = err_q;
    mv_d       = 1'b0;
    mpid_d     = mpid_q;
    mpos_d     = mpos_q;
    goto_re    = 1'b0;
    fail_re    = 1'b0;
    out_re     = 1'b0;
    goto_raddr = '0;
    tab_raddr  = '0;
    // An invalid failure entry means "fall back to root".
    fail_next  = fail_rdata_q[STATE_W] ? fail_rdata_q[STATE_W-1:0] : '0;

    if (EN) begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            char_d     = CHARA;
            cpos_d     = pos_q;
            pos_d      = pos_q + 1'b1;
            goto_re    = 1'b1;
            goto_raddr = {now_q, CHARA};
            fsm_d      = G_WAIT;
          end
        end
        G_WAIT: begin
          if (goto_rdata_q[STATE_W]) begin
            now_d     = goto_rdata_q[STATE_W-1:0];
            out_re    = 1'b1;
            tab_raddr = goto_rdata_q[STATE_W-1:0];
            fsm_d     = O_WAIT;
          end else if (now_q == '0) begin
            out_re    = 1'b1;
            fsm_d     = O_WAIT;
          end else if (hop_q == HOP_MAX) begin
            // Runaway failure chain: give up at root and flag it.
            now_d     = '0;
            err_d     = 1'b1;
            out_re    = 1'b1;
            fsm_d     = O_WAIT;
          end else begin
            fail_re   = 1'b1;
            tab_raddr = now_q;
            hop_d     = hop_q + 1'b1;
            fsm_d     = F_WAIT;
          end
        end
        F_WAIT: begin
          now_d      = fail_next;
          goto_re    = 1'b1;
          goto_raddr = {fail_next, char_q};
          fsm_d      = G_WAIT;
        end
        O_WAIT: begin
          if (out_rdata_q[PID_W]) begin
            mv_d   = 1'b1;
            mpid_d = out_rdata_q[PID_W-1:0];
            mpos_d = cpos_q;
          end
          hop_d = '0;
          fsm_d = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fsm_q  <= IDLE;
      now_q  <= '0;
      char_q <= '0;
      pos_q  <= '0;
      cpos_q <= '0;
      hop_q  <= '0;
      err_q  <= 1'b0;
      mv_q   <= 1'b0;
      mpid_q <= '0;
      mpos_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      now_q  <= now_d;
      char_q <= char_d;
      pos_q  <= pos_d;
      cpos_q <= cpos_d;
      hop_q  <= hop_d;
      err_q  <= err_d;
      mv_q   <= mv_d;
      mpid_q <= mpid_d;
      mpos_q <= mpos_d;
    end
  end

  // Table RAMs: contents survive reset; read data registers only load when
  // a read is issued, so they hold across EN-low stalls.
  always_ff @(posedge CLK) begin
    if (cfg_wr) begin
      case (CFG_SEL)
        2'd0: goto_mem[CFG_ADDR] <= CFG_WDATA;
        2'd1: fail_mem[CFG_ADDR[STATE_W-1:0]] <= CFG_WDATA;
        2'd2: out_mem[CFG_ADDR[STATE_W-1:0]] <= {CFG_WDATA[STATE_W], CFG_WDATA[PID_W-1:0]};
        default: ;
      endcase
    end
    if (goto_re) goto_rdata_q <= goto_mem[goto_raddr];
    if (fail_re) fail_rdata_q <= fail_mem[tab_raddr];
    if (out_re)  out_rdata_q  <= out_mem[tab_raddr];
  end

`ifdef MATCH_COUNT_EN
  logic [POS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (mv_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign MATCH_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_ac_stream_matcher.sv
module tb_ac_stream_matcher;

  localparam int unsigned STATE_W = 8;
  localparam int unsigned CHAR_W  = 4;
  localparam int unsigned PID_W   = 4;
  localparam int unsigned POS_W   = 4;

  logic                      CLK = 1'b0;
  logic                      RST;
  logic                      EN;
  logic                      CFG_WE;
  logic [1:0]                CFG_SEL;
  logic [STATE_W+CHAR_W-1:0] CFG_ADDR;
  logic [STATE_W:0]          CFG_WDATA;
  logic                      CHARA_VALID;
  logic [CHAR_W-1:0]         CHARA;
  logic                      CHARA_READY;
  logic                      MATCH_VALID;
  logic [PID_W-1:0]          MATCH_PID;
  logic [POS_W-1:0]          MATCH_POS;
  logic [STATE_W-1:0]        NOW_STATE;
  logic                      BUSY;
  logic                      ERR;
`ifdef MATCH_COUNT_EN
  logic [POS_W-1:0]          MATCH_CNT;
`endif

  ac_stream_matcher #(
    .STATE_W(STATE_W),
    .CHAR_W (CHAR_W),
    .PID_W  (PID_W),
    .POS_W  (POS_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .CFG_WE     (CFG_WE),
    .CFG_SEL    (CFG_SEL),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_WDATA  (CFG_WDATA),
    .CHARA_VALID(CHARA_VALID),
    .CHARA      (CHARA),
    .CHARA_READY(CHARA_READY),
    .MATCH_VALID(MATCH_VALID),
    .MATCH_PID  (MATCH_PID),
    .MATCH_POS  (MATCH_POS),
    .NOW_STATE  (NOW_STATE),
    .BUSY       (BUSY),
    .ERR        (ERR)
`ifdef MATCH_COUNT_EN
    ,
    .MATCH_CNT  (MATCH_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {int pid; int pos; int acc; int lat;} exp_t;

  exp_t  mq[$];
  int    sq[$];
  int    cmp_n = 0;
  int    err_n = 0;
  int    cyc = 0;
  bit    en_rand = 1'b0;
  bit    en_hold = 1'b0;
  string ALPH = "hesriu";
  string pats[4] = '{"he", "she", "his", "hers"};
  string nodes[$];
  int    fail_tab[16];
  string hist = "";
  int    mpos = 0;

  task automatic check(string name, int got, int exp);
    cmp_n++;
    if (got != exp) begin
      err_n++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  function automatic int find_node(string s);
    foreach (nodes[i]) if (nodes[i] == s) return i;
    return -1;
  endfunction

  function automatic int pat_pid(string s);
    foreach (pats[i]) if (pats[i] == s) return i + 1;
    return 0;
  endfunction

  function automatic int code(string c);
    for (int k = 0; k < ALPH.len(); k++) if (ALPH.substr(k, k) == c) return k + 1;
    return 0;
  endfunction

  // Reference: the automaton state is the longest suffix of the text that is
  // a dictionary prefix; the reported pattern is the longest dictionary word
  // that is a suffix of the text.
  function automatic void model_step(string c, output int st, output int pid);
    string s;
    hist = {hist, c};
    if (hist.len() > 8) hist = hist.substr(hist.len() - 8, hist.len() - 1);
    st = -1;
    pid = 0;
    for (int k = 0; k < hist.len(); k++) begin
      s = hist.substr(k, hist.len() - 1);
      if (st < 0 && find_node(s) >= 0) st = find_node(s);
      if (pid == 0) pid = pat_pid(s);
    end
    if (st < 0) st = 0;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  initial begin
    EN = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      EN = en_rand ? ($urandom_range(0, 3) != 0) : en_hold;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: match pulses and end-of-walk states against the scoreboard.
  initial begin
    exp_t e;
    bit   busy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (MATCH_VALID) begin
        if (mq.size() == 0) begin
          cmp_n++;
          err_n++;
          $display("FAIL unexpected_match: got pid %0d pos %0d, required no pulse", MATCH_PID, MATCH_POS);
        end else begin
          e = mq.pop_front();
          check("match_pid", int'(MATCH_PID), e.pid);
          check("match_pos", int'(MATCH_POS), e.pos);
          if (e.lat >= 0) check("match_latency", cyc - e.acc, e.lat);
        end
      end
      if (busy_prev && !BUSY && RST && sq.size() > 0)
        check("walk_state", int'(NOW_STATE), sq.pop_front());
      busy_prev = BUSY;
    end
  end

  task automatic cfg_write(int sel, int addr, int data);
    CFG_WE    = 1'b1;
    CFG_SEL   = sel[1:0];
    CFG_ADDR  = addr[STATE_W+CHAR_W-1:0];
    CFG_WDATA = data[STATE_W:0];
    @(negedge CLK);
    CFG_WE    = 1'b0;
  endtask

  task automatic build_and_load();
    string s, t;
    int par, c, f, pid;
    for (int a = 0; a < (1 << (STATE_W + CHAR_W)); a++) cfg_write(0, a, 0);
    for (int a = 0; a < (1 << STATE_W); a++) begin
      cfg_write(1, a, 0);
      cfg_write(2, a, 0);
    end
    nodes.delete();
    nodes.push_back("");
    foreach (pats[p])
      for (int l = 1; l <= pats[p].len(); l++) begin
        s = pats[p].substr(0, l - 1);
        if (find_node(s) < 0) nodes.push_back(s);
      end
    for (int n = 1; n < nodes.size(); n++) begin
      s   = nodes[n];
      par = (s.len() == 1) ? 0 : find_node(s.substr(0, s.len() - 2));
      c   = code(s.substr(s.len() - 1, s.len() - 1));
      cfg_write(0, par * 16 + c, 256 + n);
      f = 0;
      for (int k = 1; k < s.len(); k++) begin
        t = s.substr(k, s.len() - 1);
        if (find_node(t) >= 0) begin
          f = find_node(t);
          break;
        end
      end
      fail_tab[n] = f;
      cfg_write(1, n, 256 + f);
      pid = 0;
      for (int k = 0; k < s.len(); k++)
        if (pid == 0) pid = pat_pid(s.substr(k, s.len() - 1));
      if (pid > 0) cfg_write(2, n, 256 + pid);
    end
  endtask

  // Offer one char, wait for acceptance, record expectations. Returns at the
  // falling edge after the accepting edge with acc = cycle of acceptance.
  task automatic send(string c, int lat, output int acc);
    int st, pid, t;
    exp_t e;
    CHARA       = code(c);
    CHARA_VALID = 1'b1;
    t = 0;
    #1;
    while (!CHARA_READY && t < 4000) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (t >= 4000) check("accept_timeout", 1, 0);
    acc = cyc;
    model_step(c, st, pid);
    sq.push_back(st);
    if (pid > 0) begin
      e.pid = pid; e.pos = mpos; e.acc = acc; e.lat = lat;
      mq.push_back(e);
    end
    mpos = (mpos + 1) % (1 << POS_W);
    @(negedge CLK);
    CHARA_VALID = 1'b0;
  endtask

  task automatic send_str(string s);
    int a;
    for (int i = 0; i < s.len(); i++) send(s.substr(i, i), -1, a);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (BUSY && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 4000) check("idle_timeout", 1, 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int a0, a1, a2, a3, walk;
    RST = 1'b0; CFG_WE = 1'b0; CFG_SEL = '0; CFG_ADDR = '0; CFG_WDATA = '0;
    CHARA_VALID = 1'b0; CHARA = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(BUSY), 0);
    check("rst_state", int'(NOW_STATE), 0);
    check("rst_match_valid", int'(MATCH_VALID), 0);
    check("rst_match_pid", int'(MATCH_PID), 0);
    check("rst_match_pos", int'(MATCH_POS), 0);
    check("rst_err", int'(ERR), 0);
    RST = 1'b1;
    en_hold = 1'b1;
    repeat (2) @(negedge CLK);
    build_and_load();

    // Dictionary example: she at pos 3, hers at pos 5.
    send_str("ushers");
    wait_idle();

    // Back-to-back h,i,s from root: one accept every 3 cycles, match at +3.
    send_str("uu");
    send("h", 3, a1);
    send("i", 3, a2);
    send("s", 3, a3);
    check("ready_spacing_1", a2 - a1, 3);
    check("ready_spacing_2", a3 - a2, 3);
    wait_idle();

    // s,h,i needs one failure hop from "sh" to "h".
    send_str("ush");
    wait_idle();
    send("i", -1, a0);
    walk = 0;
    while (BUSY && walk < 100) begin
      @(negedge CLK);
      walk++;
    end
    check("fail_hop_walk", cyc - a0, 5);
    check("fail_hop_state", int'(NOW_STATE), find_node("hi"));
    wait_idle();

    // Failure loop between states 1 and 2 trips the hop limit.
    send_str("uh");
    wait_idle();
    cfg_write(1, 1, 256 + 2);
    cfg_write(1, 2, 256 + 1);
    send_str("u");
    wait_idle();
    check("loop_err", int'(ERR), 1);
    check("loop_state", int'(NOW_STATE), 0);
    check("loop_busy", int'(BUSY), 0);
    cfg_write(1, 1, 256 + fail_tab[1]);
    cfg_write(1, 2, 256 + fail_tab[2]);
    send_str("he");
    wait_idle();
    check("err_sticky", int'(ERR), 1);

    // Reset during F_WAIT abandons the char; tables survive.
    send_str("ush");
    wait_idle();
    send("i", -1, a0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_state", int'(NOW_STATE), 0);
    check("midrst_match_valid", int'(MATCH_VALID), 0);
    check("midrst_err", int'(ERR), 0);
    sq.delete();
    mq.delete();
    hist = "";
    mpos = 0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_str("ushers");
    wait_idle();

    // CFG_WE blocks acceptance; a write during BUSY is dropped.
    CFG_WE = 1'b1; CFG_SEL = 2'd3; CHARA_VALID = 1'b1; CHARA = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cfg_blocks_ready", int'(CHARA_READY), 0);
      @(negedge CLK);
      check("cfg_blocks_busy", int'(BUSY), 0);
    end
    CFG_WE = 1'b0;
    CHARA_VALID = 1'b0;
    send_str("u");
    send("s", -1, a0);
    CFG_WE = 1'b1; CFG_SEL = 2'd2; CFG_ADDR = 12'(find_node("she"));
    CFG_WDATA = 9'(256 + 9);
    @(negedge CLK);
    CFG_WE = 1'b0;
    send_str("he");
    wait_idle();

    // Random traffic with random EN stalls.
    en_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int idx;
      if ($urandom_range(0, 3) != 0) idx = $urandom_range(0, 4);
      else                           idx = $urandom_range(0, 5);
      send(ALPH.substr(idx, idx), -1, a0);
    end
    en_rand = 1'b0;
    repeat (3) @(negedge CLK);
    wait_idle();
    repeat (3) @(negedge CLK);
    check("match_queue_drained", mq.size(), 0);
    check("state_queue_drained", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/ac_stream_matcher.md
Name: ac_stream_matcher

Overview:
- Parametrised Aho-Corasick match engine; next generation of the goto/failure table pair plus table reader.
- Holds goto, failure and output tables in internal synchronous RAMs, loaded through one config write port.
- Consumes a character stream with valid/ready handshake, walks goto and failure links per character, and emits a match pulse with pattern ID and stream position.

Parameters:
- STATE_W, 8, state number width; 2^STATE_W states; state 0 is root.
- CHAR_W, 4, character width; goto RAM depth 2^(STATE_W+CHAR_W).
- PID_W, 4, pattern ID width; must be <= STATE_W.
- POS_W, 16, stream position counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-low.
- EN  in  1  engine enable; low freezes FSM and counters; RAM writes still allowed in IDLE.
- CFG_WE  in  1  table write strobe.
- CFG_SEL  in  2  table select: 0 goto, 1 failure, 2 output, 3 ignored.
- CFG_ADDR  in  STATE_W+CHAR_W  goto: {state,char}; failure/output: low STATE_W bits.
- CFG_WDATA  in  STATE_W+1  bit[STATE_W] valid flag; goto/failure: low bits next state; output: low PID_W bits PID.
- CHARA_VALID  in  1  input char valid.
- CHARA  in  CHAR_W  input character.
- CHARA_READY  out  1  engine accepts a char this cycle.
- MATCH_VALID  out  1  one-cycle match pulse.
- MATCH_PID  out  PID_W  matched pattern ID.
- MATCH_POS  out  POS_W  0-based index of the char that completed the match.
- NOW_STATE  out  STATE_W  current automaton state.
- BUSY  out  1  FSM not in IDLE.
- ERR  out  1  sticky: failure hop limit hit.

Behaviour:
- Reset (RST low at CLK edge): FSM IDLE, NOW_STATE 0, position counter 0, all outputs 0, ERR 0. RAM contents preserved. Reset mid-walk abandons the char without a match.
- RAMs: one-cycle synchronous read; address registered in cycle N, data used in cycle N+1.
- CFG: writes happen only in IDLE; CFG_WE in any other state is dropped. CHARA_READY = IDLE & EN & ~CFG_WE.
- Accept: CHARA_VALID & CHARA_READY. Latches char and position, issues goto read at {NOW_STATE,char}, goes to G_WAIT.
- G_WAIT, goto entry valid: NOW_STATE <= entry state; issue output read at that state; go to O_WAIT.
- G_WAIT, entry invalid and NOW_STATE==0: stay at root; issue output read at 0; go to O_WAIT.
- G_WAIT, entry invalid and NOW_STATE!=0: issue failure read at NOW_STATE; hop counter +1; go to F_WAIT.
- F_WAIT: NOW_STATE <= failure state; if the failure entry is invalid, use root. Reissue goto read with the new state and same char; go to G_WAIT.
- Hop limit: hop counter reaches 2^STATE_W-1 -> NOW_STATE <= 0, ERR <= 1, go to O_WAIT at root.
- O_WAIT: if output entry valid, register MATCH_VALID=1 with MATCH_PID and MATCH_POS for one cycle. Return to IDLE; clear hop counter.
- Latency: direct goto -> MATCH_VALID in cycle acceptance+3; each failure hop adds 2 cycles.
- Throughput: one char per 3 cycles best case; CHARA_READY low while BUSY.
- Output table holds one PID per state. Suffix outputs are merged by the table builder; the engine reports one PID per char.
- Position counter increments on each accept and wraps from 2^POS_W-1 to 0.
- EN low mid-walk holds all state, including pending RAM read data; the walk resumes when EN returns high.
- ERR clears only on reset.

Optional Feature:
- MATCH_COUNT_EN defined: adds output MATCH_CNT [POS_W-1:0], incremented on each MATCH_VALID, saturating at all-ones, reset 0.
- MATCH_COUNT_EN not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Load dictionary he=PID1, she=PID2, his=PID3, hers=PID4; char codes h=1, e=2, s=3, r=4, i=5, u=6. Stream u,s,h,e,r,s -> MATCH_VALID at pos 3 with PID2, then at pos 5 with PID4; no other pulses.
- Same tables, stream h,i,s back-to-back with CHARA_VALID held high -> CHARA_READY pulses once every 3 cycles; PID3 match at pos 2 arrives exactly 3 cycles after the third accept.
- Stream s,h,i (mismatch after "sh" needs a failure hop to state "h") -> walk takes 5 cycles; NOW_STATE equals the "hi" state; no match.
- Failure table with a loop (state 1 fail->2, state 2 fail->1), char without goto -> ERR=1, NOW_STATE=0, engine returns to IDLE.
- RST low during F_WAIT -> next cycle: BUSY 0, NOW_STATE 0, position counter 0, no MATCH_VALID; a re-streamed dictionary test passes without reloading tables.
- CFG_WE held high while CHARA_VALID=1 -> no char accepted; a CFG write issued during BUSY does not change a later readback match result.
